// File: rtl/mem_blk_engine.sv
// mem_blk_engine: block command engine for the single-port data memory.
// Executes FILL, COPY and SUM commands by sequencing the memory's address,
// write-enable and write-data pins, reading back through the combinational
// read port. Commands arrive on a valid/ready handshake and are fully latched
// on accept, so the requester may change the command inputs freely afterwards.

module mem_blk_engine #(
   parameter int AW = 10,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [AW-1:0] cmd_src,
   input  logic [AW-1:0] cmd_dst,
   input  logic [AW:0]   cmd_len,
   input  logic [DW-1:0] cmd_data,
   output logic [AW-1:0] mem_a,
   output logic          mem_we,
   output logic [DW-1:0] mem_d,
   input  logic [DW-1:0] mem_spo,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] result,
   output logic          err
);

   localparam logic [1:0] OP_FILL = 2'd0;
   localparam logic [1:0] OP_COPY = 2'd1;
   localparam logic [1:0] OP_RSVD = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_CP_RD,
      S_CP_WR,
      S_SUM,
      S_DONE
   } state_t;

   state_t        state;
   logic [AW-1:0] src_ptr;
   logic [AW-1:0] dst_ptr;
   logic [AW:0]   remaining;
   logic [DW-1:0] acc;
   logic          last_word;

   // The word being handled this cycle is the final one of the command.
   assign last_word = (remaining == (AW+1)'(1));

   // Handshake and status flags decode straight from the state register.
   assign cmd_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);

   // Command sequencer: all memory pins, the accumulator and the status
   // outputs are registered here so each state presents its memory cycle
   // cleanly. mem_d doubles as the COPY holding register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= S_IDLE;
         mem_a     <= '0;
         mem_we    <= 1'b0;
         mem_d     <= '0;
         done      <= 1'b0;
         result    <= '0;
         err       <= 1'b0;
         src_ptr   <= '0;
         dst_ptr   <= '0;
         remaining <= '0;
         acc       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  result    <= '0;
                  err       <= 1'b0;
                  acc       <= '0;
                  remaining <= cmd_len;
                  src_ptr   <= cmd_src;
                  dst_ptr   <= cmd_dst;
                  if (cmd_op == OP_RSVD) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else if (cmd_len == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else if (cmd_op == OP_FILL) begin
                     state  <= S_FILL;
                     mem_a  <= cmd_dst;
                     mem_we <= 1'b1;
                     mem_d  <= cmd_data;
                  end else if (cmd_op == OP_COPY) begin
                     state <= S_CP_RD;
                     mem_a <= cmd_src;
                  end else begin
                     state <= S_SUM;
                     mem_a <= cmd_src;
                  end
               end
            end

            S_FILL: begin
               remaining <= remaining - 1'b1;
               if (last_word) begin
                  state  <= S_DONE;
                  done   <= 1'b1;
                  mem_a  <= '0;
                  mem_we <= 1'b0;
                  mem_d  <= '0;
               end else begin
                  mem_a <= mem_a + 1'b1;
               end
            end

            S_CP_RD: begin
               state   <= S_CP_WR;
               mem_d   <= mem_spo;
               mem_a   <= dst_ptr;
               mem_we  <= 1'b1;
               src_ptr <= src_ptr + 1'b1;
            end

            S_CP_WR: begin
               remaining <= remaining - 1'b1;
               dst_ptr   <= dst_ptr + 1'b1;
               mem_we    <= 1'b0;
               if (last_word) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  mem_a <= '0;
                  mem_d <= '0;
               end else begin
                  state <= S_CP_RD;
                  mem_a <= src_ptr;
               end
            end

            S_SUM: begin
               remaining <= remaining - 1'b1;
               acc       <= acc + mem_spo;
               if (last_word) begin
                  state  <= S_DONE;
                  done   <= 1'b1;
                  result <= acc + mem_spo;
                  mem_a  <= '0;
               end else begin
                  mem_a <= mem_a + 1'b1;
               end
            end

            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
            end

            default: begin
               state  <= S_IDLE;
               done   <= 1'b0;
               mem_a  <= '0;
               mem_we <= 1'b0;
               mem_d  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_blk_engine.sv
// tb_mem_blk_engine: self-checking bench for mem_blk_engine.
// A behavioural model turns each accepted command into the list of memory
// cycles it must produce plus its completion cycle, and keeps a golden copy
// of memory. A compare process checks the DUT pins against that list every
// cycle; directed tests pin the model with hand-computed values.

module tb_mem_blk_engine;

   localparam int AW    = 10;
   localparam int DW    = 32;
   localparam int DEPTH = 1 << AW;

   logic          clk;
   logic          rstn;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [AW-1:0] cmd_src;
   logic [AW-1:0] cmd_dst;
   logic [AW:0]   cmd_len;
   logic [DW-1:0] cmd_data;
   logic [AW-1:0] mem_a;
   logic          mem_we;
   logic [DW-1:0] mem_d;
   logic [DW-1:0] mem_spo;
   logic          busy;
   logic          done;
   logic [DW-1:0] result;
   logic          err;

   mem_blk_engine #(.AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_src   (cmd_src),
      .cmd_dst   (cmd_dst),
      .cmd_len   (cmd_len),
      .cmd_data  (cmd_data),
      .mem_a     (mem_a),
      .mem_we    (mem_we),
      .mem_d     (mem_d),
      .mem_spo   (mem_spo),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .err       (err)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The data memory itself, with a backdoor preset port for initial contents.
   logic [DW-1:0] ram [DEPTH];
   logic          preset_en;
   logic [AW-1:0] preset_addr;
   logic [DW-1:0] preset_val;

   // Memory write port: preset has priority, otherwise the engine writes.
   always @(posedge clk) begin
      if (preset_en) ram[preset_addr] <= preset_val;
      else if (mem_we) ram[mem_a] <= mem_d;
   end

   assign mem_spo = ram[mem_a];

   // Behavioural model state.
   typedef struct packed {
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          chk_d;
      logic          done;
      logic [DW-1:0] res;
      logic          err;
   } cycle_t;

   logic [DW-1:0] golden [DEPTH];
   cycle_t        exp_q [$];
   logic [DW-1:0] held_res;
   logic          held_err;
   int            checks;
   int            errors;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic compareCycle(input cycle_t e, input logic exp_busy);
      checkOutput("cmd_ready", 32'(cmd_ready), 32'(!exp_busy));
      checkOutput("busy", 32'(busy), 32'(exp_busy));
      checkOutput("done", 32'(done), 32'(e.done));
      checkOutput("mem_we", 32'(mem_we), 32'(e.we));
      checkOutput("mem_a", 32'(mem_a), 32'(e.a));
      if (e.chk_d) checkOutput("mem_d", mem_d, e.d);
      checkOutput("result", result, e.res);
      checkOutput("err", 32'(err), 32'(e.err));
   endtask

   // Cycle-by-cycle compare against the model's expected cycle list.
   always @(negedge clk) begin
      cycle_t e;
      if (!rstn) begin
         e       = '0;
         e.chk_d = 1'b1;
         compareCycle(e, 1'b0);
      end else if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compareCycle(e, 1'b1);
         if (e.done) begin
            held_res = e.res;
            held_err = e.err;
         end
      end else begin
         e       = '0;
         e.chk_d = 1'b1;
         e.res   = held_res;
         e.err   = held_err;
         compareCycle(e, 1'b0);
      end
   end

   // Expand one command into its memory cycles and completion, updating golden.
   task automatic buildTrace(input logic [1:0] op, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                             input logic [AW:0] len, input logic [DW-1:0] data);
      cycle_t        e;
      logic [DW-1:0] sum;
      logic [AW-1:0] sa;
      logic [AW-1:0] da;
      sum = '0;
      if (op != 2'd3) begin
         for (int i = 0; i < int'(len); i++) begin
            sa = src + AW'(i);
            da = dst + AW'(i);
            e  = '0;
            if (op == 2'd0) begin
               golden[da] = data;
               e.we = 1'b1; e.a = da; e.d = data; e.chk_d = 1'b1;
               exp_q.push_back(e);
            end else if (op == 2'd1) begin
               e.a = sa;
               exp_q.push_back(e);
               golden[da] = golden[sa];
               e.we = 1'b1; e.a = da; e.d = golden[da]; e.chk_d = 1'b1;
               exp_q.push_back(e);
            end else begin
               sum = sum + golden[sa];
               e.a = sa;
               exp_q.push_back(e);
            end
         end
      end
      e       = '0;
      e.chk_d = 1'b1;
      e.done  = 1'b1;
      e.res   = (op == 2'd2) ? sum : '0;
      e.err   = (op == 2'd3);
      exp_q.push_back(e);
   endtask

   // Present a command, wait until the engine takes it, then record the model.
   task automatic acceptOnly(input logic [1:0] op, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                             input logic [AW:0] len, input logic [DW-1:0] data, input bit early);
      int wt;
      if (!early) @(negedge clk);
      #1;
      cmd_op    = op;
      cmd_src   = src;
      cmd_dst   = dst;
      cmd_len   = len;
      cmd_data  = data;
      cmd_valid = 1'b1;
      wt = 0;
      while (!cmd_ready && wt < 5000) begin
         @(negedge clk);
         #1;
         wt++;
      end
      if (!cmd_ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: cmd_ready=0, required 1 within 5000 cycles");
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_src   = AW'($urandom);
      cmd_dst   = AW'($urandom);
      cmd_len   = (AW+1)'($urandom);
      cmd_data  = $urandom;
      buildTrace(op, src, dst, len, data);
   endtask

   // Count cycles from accept until done is seen; lat=1 means the cycle after accept.
   task automatic waitDone(output int lat);
      for (lat = 1; lat <= 5000; lat++) begin
         @(negedge clk);
         if (done) break;
         @(posedge clk);
      end
      if (lat > 5000) begin
         checks++;
         errors++;
         $display("[TB] FAIL done_timeout: done=0, required 1 within 5000 cycles");
      end
   endtask

   task automatic applyStimulus(input logic [1:0] op, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                                input logic [AW:0] len, input logic [DW-1:0] data, input bit early,
                                output int lat);
      acceptOnly(op, src, dst, len, data, early);
      waitDone(lat);
   endtask

   task automatic checkMemory(input string name);
      int bad;
      bad = -1;
      for (int i = 0; i < DEPTH; i++) begin
         if (bad < 0 && ram[i] !== golden[i]) bad = i;
      end
      checks++;
      if (bad >= 0) begin
         errors++;
         $display("[TB] FAIL %s: word 0x%0h got 0x%0h, required 0x%0h", name, bad, ram[bad], golden[bad]);
      end
   endtask

   // Safety net so the run always terminates.
   initial begin
      #1500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Directed tests followed by randomized commands.
   initial begin
      int            lat;
      logic [1:0]    op;
      logic [AW-1:0] src;
      logic [AW-1:0] dst;
      logic [AW:0]   len;
      logic [DW-1:0] data;
      bit            early;
      int            exp_lat;
      logic [DW-1:0] saved [8];

      checks    = 0;
      errors    = 0;
      held_res  = '0;
      held_err  = 1'b0;
      rstn      = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_src   = '0;
      cmd_dst   = '0;
      cmd_len   = '0;
      cmd_data  = '0;
      preset_en = 1'b0;
      preset_addr = '0;
      preset_val  = '0;

      #1 rstn = 1'b0;
      #1;
      $display("[TB] checking reset state");
      checkOutput("reset_ready", 32'(cmd_ready), 32'd1);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_we", 32'(mem_we), 32'd0);
      checkOutput("reset_result", result, 32'd0);
      repeat (3) @(negedge clk);
      #1 rstn = 1'b1;

      // Preset every word to its own index.
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         preset_en   = 1'b1;
         preset_addr = AW'(i);
         preset_val  = DW'(i);
         golden[i]   = DW'(i);
      end
      @(negedge clk);
      preset_en = 1'b0;

      $display("[TB] SUM of words 0..99");
      applyStimulus(2'd2, 10'd0, 10'd0, 11'd100, 32'h0, 1'b0, lat);
      checkOutput("sum100_lat", 32'(lat), 32'd101);
      checkOutput("sum100_result", result, 32'h1356);
      checkOutput("sum100_err", 32'(err), 32'd0);

      $display("[TB] COPY 10..14 to 20..24");
      applyStimulus(2'd1, 10'd10, 10'd20, 11'd5, 32'h0, 1'b0, lat);
      checkOutput("copy_lat", 32'(lat), 32'd11);
      @(negedge clk);
      checkOutput("copy_w20", ram[20], 32'd10);
      checkOutput("copy_w24", ram[24], 32'd14);
      checkOutput("copy_src10", ram[10], 32'd10);

      $display("[TB] FILL wrapping past the top of memory");
      applyStimulus(2'd0, 10'd0, 10'h3FE, 11'd4, 32'hDEADBEEF, 1'b0, lat);
      checkOutput("fill_lat", 32'(lat), 32'd5);
      @(negedge clk);
      checkOutput("fill_w3fe", ram[10'h3FE], 32'hDEADBEEF);
      checkOutput("fill_w3ff", ram[10'h3FF], 32'hDEADBEEF);
      checkOutput("fill_w000", ram[0], 32'hDEADBEEF);
      checkOutput("fill_w001", ram[1], 32'hDEADBEEF);
      checkOutput("fill_w002", ram[2], 32'd2);

      $display("[TB] overlapping COPY replicates word 0");
      applyStimulus(2'd1, 10'd0, 10'd1, 11'd3, 32'h0, 1'b0, lat);
      @(negedge clk);
      checkOutput("ovl_w3", ram[3], 32'hDEADBEEF);
      checkOutput("ovl_w4", ram[4], 32'd4);

      $display("[TB] zero-length and reserved commands");
      applyStimulus(2'd0, 10'd0, 10'd50, 11'd0, 32'h55, 1'b1, lat);
      checkOutput("len0_lat", 32'(lat), 32'd1);
      checkOutput("len0_err", 32'(err), 32'd0);
      checkOutput("len0_result", result, 32'd0);
      applyStimulus(2'd3, 10'd7, 10'd9, 11'd5, 32'h0, 1'b1, lat);
      checkOutput("rsvd_lat", 32'(lat), 32'd1);
      checkOutput("rsvd_err", 32'(err), 32'd1);
      checkMemory("mem_after_directed");

      $display("[TB] full-memory FILL and SUM");
      applyStimulus(2'd0, 10'd0, 10'd0, 11'd1024, 32'hFFFFFFFF, 1'b0, lat);
      checkOutput("fillall_lat", 32'(lat), 32'd1025);
      applyStimulus(2'd2, 10'd0, 10'd0, 11'd1024, 32'h0, 1'b0, lat);
      checkOutput("sumall_lat", 32'(lat), 32'd1025);
      checkOutput("sumall_result", result, 32'hFFFFFC00);

      $display("[TB] reset during FILL");
      for (int i = 0; i < 8; i++) saved[i] = golden[100 + i];
      acceptOnly(2'd0, 10'd0, 10'd100, 11'd8, 32'h12345678, 1'b0);
      repeat (3) @(negedge clk);
      #1;
      rstn = 1'b0;
      exp_q.delete();
      held_res = '0;
      held_err = 1'b0;
      #1;
      checkOutput("abort_we", 32'(mem_we), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_ready", 32'(cmd_ready), 32'd1);
      for (int i = 2; i < 8; i++) golden[100 + i] = saved[i];
      repeat (2) @(negedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      checkOutput("abort_w101", ram[101], 32'h12345678);
      checkOutput("abort_w102", ram[102], 32'hFFFFFFFF);
      checkMemory("mem_after_abort");
      applyStimulus(2'd2, 10'd98, 10'd0, 11'd12, 32'h0, 1'b0, lat);
      checkOutput("post_abort_lat", 32'(lat), 32'd13);

      $display("[TB] randomized commands");
      for (int n = 0; n < 80; n++) begin
         op    = 2'($urandom_range(0, 3));
         src   = AW'($urandom);
         dst   = AW'($urandom);
         data  = $urandom;
         early = bit'($urandom_range(0, 1));
         case ($urandom_range(0, 19))
            0:       len = '0;
            1:       len = (AW+1)'($urandom_range(200, 1024));
            default: len = (AW+1)'($urandom_range(1, 24));
         endcase
         if (op == 2'd3 || len == '0) exp_lat = 1;
         else if (op == 2'd1) exp_lat = 2 * int'(len) + 1;
         else exp_lat = int'(len) + 1;
         applyStimulus(op, src, dst, len, data, early, lat);
         checkOutput("rand_lat", 32'(lat), 32'(exp_lat));
      end
      repeat (2) @(negedge clk);
      checkMemory("mem_final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
